// File: rtl/cut_sweep_ctrl.sv
// cut_sweep_ctrl: steps a small combinational CUT through its input space
// (or one chosen vector), waits a programmable settle time per vector, then
// records the CUT outputs in a truth-table RAM and folds them into a MISR.
module cut_sweep_ctrl #(
   parameter int                N_IN   = 6,
   parameter int                N_OUT  = 4,
   parameter int                SETTLE = 2,
   parameter int                SIG_W  = 16,
   parameter logic [SIG_W-1:0]  POLY   = 16'h1021
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [N_IN-1:0]   vec_in,
   input  logic              abort,
   output logic [N_IN-1:0]   cut_x,
   input  logic [N_OUT-1:0]  cut_f,
   output logic              busy,
   output logic              done,
   output logic [SIG_W-1:0]  signature,
   input  logic [N_IN-1:0]   rd_addr,
   output logic [N_OUT-1:0]  rd_data
);

   localparam int              DEPTH  = 2 ** N_IN;
   localparam logic [N_IN-1:0] LAST_X = '1;
   localparam logic [N_IN-1:0] ONE_X  = N_IN'(1);
   localparam logic [7:0]      RELOAD = 8'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [N_IN-1:0]   cut_x_q, cut_x_d;
   logic              mode_q, mode_d;
   logic [SIG_W-1:0]  sig_q, sig_d;
   logic [N_OUT-1:0]  rd_data_q, rd_data_d;
   logic [SIG_W-1:0]  misr_next;
   logic              cap_we;

   // Truth-table storage; deliberately not reset so captured data survives aborts and resets.
   logic [N_OUT-1:0]  tt_mem [DEPTH];

   // One MISR step: shift left, fold the polynomial when the MSB falls out, inject the CUT outputs.
   always_comb begin
      misr_next = {sig_q[SIG_W-2:0], 1'b0}
                ^ (sig_q[SIG_W-1] ? POLY : '0)
                ^ SIG_W'(cut_f);
   end

   // Next-state logic for the sweep sequencer and its datapath registers.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cut_x_d = cut_x_q;
      mode_d  = mode_q;
      sig_d   = sig_q;
      cap_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            // abort wins over a coincident start
            if (start && !abort) begin
               state_d = S_SETTLE;
               mode_d  = mode;
               cut_x_d = mode ? vec_in : '0;
               sig_d   = '0;
               cnt_d   = RELOAD;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               state_d = S_IDLE;
               cut_x_d = '0;
            end else if (cnt_q == 8'd0) begin
               state_d = S_CAPTURE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_CAPTURE: begin
            // an abort here drops the pending capture: only completed vectors are recorded
            if (abort) begin
               state_d = S_IDLE;
               cut_x_d = '0;
            end else begin
               cap_we = 1'b1;
               sig_d  = misr_next;
               if (mode_q || (cut_x_q == LAST_X)) begin
                  state_d = S_DONE;
               end else begin
                  cut_x_d = cut_x_q + ONE_X;
                  cnt_d   = RELOAD;
                  state_d = S_SETTLE;
               end
            end
         end
         S_DONE: begin
            // cut_x keeps the last vector; start and abort have no effect here
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Sequencer and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         cut_x_q <= '0;
         mode_q  <= 1'b0;
         sig_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cut_x_q <= cut_x_d;
         mode_q  <= mode_d;
         sig_q   <= sig_d;
      end
   end

   // Capture port of the truth table: the vector is stable for the whole window, so index by cut_x_q.
   always_ff @(posedge clk) begin
      if (cap_we) begin
         tt_mem[cut_x_q] <= cut_f;
      end
   end

   // Read port address decode; a same-cycle capture is not forwarded, so old data is returned.
   always_comb begin
      rd_data_d = tt_mem[rd_addr];
   end

   // Registered read data, one cycle after the address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign cut_x     = cut_x_q;
   assign busy      = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
   assign done      = (state_q == S_DONE);
   assign signature = sig_q;
   assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_cut_sweep_ctrl.sv
// Scoreboard bench for cut_sweep_ctrl: three instances (SETTLE = 2, 1, 5),
// a reference model of the sweep, and a monitor that pops expected done
// events and read responses as the DUTs present them.
`timescale 1ns/1ps
module tb_cut_sweep_ctrl;

   localparam logic [15:0] POLY = 16'h1021;

   typedef struct {
      int          cyc;
      logic [15:0] sig;
      logic [5:0]  x;
   } dexp_t;

   logic        clk = 1'b0;
   logic        rst;
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   // index 0: SETTLE=2 (main), 1: SETTLE=1, 2: SETTLE=5
   logic        start_a [3];
   logic [5:0]  rd_addr_a [3];
   logic        rd_req [3];
   logic        rd_req_d [3];
   logic [5:0]  cutx_w [3];
   logic        busy_w [3];
   logic        done_w [3];
   logic [15:0] sig_w [3];
   logic [3:0]  rd_w [3];
   logic [3:0]  f_w [3];

   logic        mode0, abort0;
   logic [5:0]  vec0;
   logic        use_lut;
   logic [3:0]  lut [64];
   logic [15:0] dly5 = 16'h0;

   // reference model state
   logic [3:0]  tbl_m [3][64];
   dexp_t       dq [3][$];
   logic [3:0]  rq [3][$];
   bit          run_on = 1'b0;
   int          run_s = 0;
   int          run_end = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // CUT models: main uses a stub or a random LUT; SETTLE=5 instance sees outputs 4 cycles late
   always @(posedge clk) dly5 <= {dly5[11:0], cutx_w[2][3:0]};
   always_comb begin
      f_w[0] = use_lut ? lut[cutx_w[0]] : cutx_w[0][3:0];
      f_w[1] = cutx_w[1][3:0];
      f_w[2] = dly5[15:12];
   end

   cut_sweep_ctrl #(.SETTLE(2)) u_s2 (
      .clk(clk), .rst(rst), .start(start_a[0]), .mode(mode0), .vec_in(vec0), .abort(abort0),
      .cut_x(cutx_w[0]), .cut_f(f_w[0]), .busy(busy_w[0]), .done(done_w[0]),
      .signature(sig_w[0]), .rd_addr(rd_addr_a[0]), .rd_data(rd_w[0]));

   cut_sweep_ctrl #(.SETTLE(1)) u_s1 (
      .clk(clk), .rst(rst), .start(start_a[1]), .mode(1'b0), .vec_in(6'd0), .abort(1'b0),
      .cut_x(cutx_w[1]), .cut_f(f_w[1]), .busy(busy_w[1]), .done(done_w[1]),
      .signature(sig_w[1]), .rd_addr(rd_addr_a[1]), .rd_data(rd_w[1]));

   cut_sweep_ctrl #(.SETTLE(5)) u_s5 (
      .clk(clk), .rst(rst), .start(start_a[2]), .mode(1'b0), .vec_in(6'd0), .abort(1'b0),
      .cut_x(cutx_w[2]), .cut_f(f_w[2]), .busy(busy_w[2]), .done(done_w[2]),
      .signature(sig_w[2]), .rd_addr(rd_addr_a[2]), .rd_data(rd_w[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] cut_fn(input int idx, input logic [5:0] x);
      if (idx == 0 && use_lut) return lut[x];
      return x[3:0];
   endfunction

   function automatic logic [15:0] misr(input logic [15:0] s, input logic [3:0] f);
      return {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0) ^ {12'h0, f};
   endfunction

   // Captures the first n vectors of a run into the model table; returns the resulting signature.
   function automatic logic [15:0] model_run(input int idx, input logic m, input logic [5:0] v, input int n);
      logic [15:0] s = 16'h0;
      for (int j = 0; j < n; j++) begin
         logic [5:0] x = m ? v : 6'(j);
         tbl_m[idx][x] = cut_fn(idx, x);
         s = misr(s, tbl_m[idx][x]);
      end
      return s;
   endfunction

   // Monitor: compares done events and read responses against the queued expectations.
   always @(posedge clk) for (int i = 0; i < 3; i++) rd_req_d[i] <= rd_req[i];
   always @(negedge clk) begin
      dexp_t e;
      for (int i = 0; i < 3; i++) begin
         if (done_w[i] === 1'b1) begin
            if (dq[i].size() == 0) begin
               fail_now($sformatf("unexpected_done[%0d]", i));
            end else begin
               e = dq[i].pop_front();
               $display("[TB] done[%0d] cycle %0d sig %04h cut_x %02h", i, cyc, sig_w[i], cutx_w[i]);
               check($sformatf("done_cycle[%0d]", i), cyc, e.cyc);
               check($sformatf("done_sig[%0d]", i), sig_w[i], e.sig);
               check($sformatf("done_cutx[%0d]", i), cutx_w[i], e.x);
            end
         end
         if (rd_req_d[i]) begin
            if (rq[i].size() == 0) fail_now($sformatf("unexpected_read[%0d]", i));
            else check($sformatf("rd_data[%0d]", i), rd_w[i], rq[i].pop_front());
         end
      end
      check("busy", busy_w[0], run_on && cyc > run_s && cyc < run_end);
   end

   task automatic check_reset_vals(input string tag);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_cutx[%0d]", tag, i), cutx_w[i], 6'h0);
         check($sformatf("%s_busy[%0d]", tag, i), busy_w[i], 1'b0);
         check($sformatf("%s_done[%0d]", tag, i), done_w[i], 1'b0);
         check($sformatf("%s_sig[%0d]", tag, i), sig_w[i], 16'h0);
         check($sformatf("%s_rd[%0d]", tag, i), rd_w[i], 4'h0);
      end
   endtask

   task automatic read_range(input int idx, input int lo, input int hi);
      for (int a = lo; a <= hi; a++) begin
         rd_addr_a[idx] = 6'(a);
         rd_req[idx]    = 1'b1;
         rq[idx].push_back(tbl_m[idx][a]);
         tick;
      end
      rd_req[idx] = 1'b0;
      tick;
      tick;
   endtask

   task automatic randomize_lut;
      for (int k = 0; k < 64; k++) lut[k] = 4'($urandom);
   endtask

   // Full run on the main instance; optionally re-pulses start mid-run and in the DONE cycle.
   task automatic run_main(input logic m, input logic [5:0] v, input bit repulse);
      int          s, n, endc;
      logic [15:0] sg;
      dexp_t       e;
      n = m ? 1 : 64;
      s = cyc;
      mode0 = m; vec0 = v; start_a[0] = 1'b1;
      sg = model_run(0, m, v, n);
      endc = s + 1 + n * 3;
      e.cyc = endc; e.sig = sg; e.x = m ? v : 6'h3F;
      dq[0].push_back(e);
      run_on = 1'b1; run_s = s; run_end = endc;
      $display("[TB] start mode %0d vec %02h at cycle %0d, expect done at %0d sig %04h", m, v, s, endc, sg);
      tick;
      start_a[0] = 1'b0;
      mode0 = 1'($urandom); vec0 = 6'($urandom);
      check("cutx_first", cutx_w[0], m ? v : 6'h0);
      while (cyc < endc + 1) begin
         start_a[0] = repulse && (cyc == s + 10 || cyc == s + 100 || cyc == endc);
         tick;
      end
      start_a[0] = 1'b0;
      check("sig_hold", sig_w[0], sg);
   endtask

   // Exhaustive run aborted at cycle offset o (never a capture cycle).
   task automatic run_abort(input int o);
      int          s;
      logic [15:0] sg;
      s = cyc;
      mode0 = 1'b0; start_a[0] = 1'b1;
      sg = model_run(0, 1'b0, 6'h0, (o - 1) / 3);
      run_on = 1'b1; run_s = s; run_end = s + o + 1;
      $display("[TB] abort run at offset %0d, %0d vectors captured, partial sig %04h", o, (o - 1) / 3, sg);
      tick;
      start_a[0] = 1'b0;
      while (cyc < s + o) tick;
      abort0 = 1'b1;
      tick;
      abort0 = 1'b0;
      check("abort_cutx", cutx_w[0], 6'h0);
      check("abort_sig", sig_w[0], sg);
      repeat (5) tick;
      check("abort_sig_hold", sig_w[0], sg);
   endtask

   // Single-vector run with reads of the same address around the capture edge.
   task automatic run_collide(input logic [5:0] v);
      int          s;
      logic [3:0]  old_d, new_d;
      logic [15:0] sg;
      dexp_t       e;
      old_d = tbl_m[0][v];
      lut[v] = old_d ^ 4'($urandom_range(1, 15));
      s = cyc;
      mode0 = 1'b1; vec0 = v;
      sg = model_run(0, 1'b1, v, 1);
      new_d = tbl_m[0][v];
      e.cyc = s + 4; e.sig = sg; e.x = v;
      dq[0].push_back(e);
      run_on = 1'b1; run_s = s; run_end = s + 4;
      $display("[TB] collide read at %02h: old %0h new %0h", v, old_d, new_d);
      for (int k = 0; k < 6; k++) begin
         start_a[0]   = (k == 0);
         rd_addr_a[0] = v;
         rd_req[0]    = 1'b1;
         rq[0].push_back((cyc <= s + 3) ? old_d : new_d);
         tick;
      end
      start_a[0] = 1'b0;
      rd_req[0]  = 1'b0;
      tick;
      tick;
   endtask

   initial begin
      #(5_000_000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          s;
      logic [15:0] sg;
      dexp_t       e;
      rst = 1'b1;
      mode0 = 1'b0; vec0 = 6'h0; abort0 = 1'b0; use_lut = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start_a[i] = 1'b0; rd_addr_a[i] = 6'h0; rd_req[i] = 1'b0;
      end
      randomize_lut();
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst = 1'b0;
      tick;

      // single vector, stub CUT
      run_main(1'b1, 6'h15, 1'b0);
      check("t1_sig", sig_w[0], 16'h0005);
      read_range(0, 6'h15, 6'h15);

      // exhaustive sweep, then again with start re-pulsed
      run_main(1'b0, 6'h0, 1'b0);
      read_range(0, 0, 63);
      run_main(1'b0, 6'h0, 1'b1);
      read_range(0, 0, 63);

      // abort at offset 50, then random aborts with a fresh CUT function
      run_abort(50);
      read_range(0, 0, 15);
      use_lut = 1'b1;
      for (int r = 0; r < 3; r++) begin
         randomize_lut();
         run_abort(3 * $urandom_range(0, 63) + $urandom_range(1, 2));
         read_range(0, 0, 63);
      end

      // start and abort together in IDLE: nothing happens
      start_a[0] = 1'b1; abort0 = 1'b1; mode0 = 1'b1; vec0 = 6'h2A;
      run_on = 1'b0;
      tick;
      start_a[0] = 1'b0; abort0 = 1'b0;
      check("idle_abort_cutx", cutx_w[0], 6'h0);
      repeat (4) tick;
      check("idle_abort_cutx2", cutx_w[0], 6'h0);

      // read/capture collision on a random vector
      run_collide(6'($urandom));

      // asynchronous reset at cycle 20 of a sweep, then a normal sweep
      randomize_lut();
      s = cyc;
      mode0 = 1'b0; start_a[0] = 1'b1;
      void'(model_run(0, 1'b0, 6'h0, 6));
      run_on = 1'b1; run_s = s; run_end = s + 20;
      tick;
      start_a[0] = 1'b0;
      while (cyc < s + 20) tick;
      rst = 1'b1;
      #1;
      $display("[TB] reset asserted at offset %0d", cyc - s);
      check_reset_vals("midrst");
      tick;
      tick;
      rst = 1'b0;
      tick;
      read_range(0, 0, 63);
      randomize_lut();
      run_main(1'b0, 6'h0, 1'b0);
      read_range(0, 0, 63);

      // SETTLE=1 and SETTLE=5 instances in parallel
      s = cyc;
      start_a[1] = 1'b1; start_a[2] = 1'b1;
      sg = model_run(1, 1'b0, 6'h0, 64);
      void'(model_run(2, 1'b0, 6'h0, 64));
      e.sig = sg; e.x = 6'h3F;
      e.cyc = s + 129; dq[1].push_back(e);
      e.cyc = s + 385; dq[2].push_back(e);
      tick;
      start_a[1] = 1'b0; start_a[2] = 1'b0;
      while (cyc < s + 390) tick;
      read_range(1, 0, 63);
      read_range(2, 0, 63);

      repeat (4) tick;
      for (int i = 0; i < 3; i++) begin
         if (dq[i].size() != 0) fail_now($sformatf("missing_done[%0d]", i));
         if (rq[i].size() != 0) fail_now($sformatf("missing_read[%0d]", i));
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cut_sweep_ctrl.md
Name: cut_sweep_ctrl

Overview:
- Sequencer that drives a 6-input / 4-output combinational circuit-under-test (CUT) from the generated-circuit set through input vectors.
- Waits a programmable settle time per vector, then captures the CUT outputs into a 64-entry truth-table buffer and folds them into a MISR signature.
- Sits between the CUT and a host or test harness; that side uses a start/busy/done handshake and a synchronous read port.

Parameters:
- N_IN, 6, CUT input width; the table holds 2**N_IN entries.
- N_OUT, 4, CUT output width.
- SETTLE, 2, settle cycles per vector before capture; legal range 1..255.
- SIG_W, 16, MISR width; must be >= N_OUT.
- POLY, 16'h1021, MISR feedback polynomial.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- mode  in  1  0 = exhaustive sweep, 1 = single vector.
- vec_in  in  N_IN  vector used when mode=1; latched at start.
- abort  in  1  terminate the run.
- cut_x  out  N_IN  registered vector driven to the CUT.
- cut_f  in  N_OUT  CUT outputs.
- busy  out  1  high from the cycle after start until the run ends.
- done  out  1  one-cycle pulse on normal completion.
- signature  out  SIG_W  MISR value; holds after the run.
- rd_addr  in  N_IN  truth-table read address.
- rd_data  out  N_OUT  table[rd_addr], one-cycle latency.

Behaviour:
- Reset values: cut_x=0, busy=0, done=0, signature=0, rd_data=0, FSM=IDLE, settle counter=0. Table contents are not reset.
- FSM states:
  - IDLE: start=1 and abort=0 → SETTLE, with the following effects:
    - mode and vec_in are latched;
    - cut_x = 0 (mode 0) or vec_in (mode 1);
    - signature = 0, counter = SETTLE-1, busy = 1.
  - SETTLE: counter decrements each cycle; at 0 → CAPTURE.
  - CAPTURE (1 cycle): table[cut_x] <= cut_f, and the MISR updates.
    - If mode=1, or mode=0 and cut_x == 2**N_IN-1 → DONE.
    - Otherwise cut_x increments, counter reloads SETTLE-1, → SETTLE.
  - DONE (1 cycle): done=1, busy=0; cut_x stays at the last vector; → IDLE.
- MISR update: sig <= (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_extend(cut_f).
- Timing: start sampled at cycle 0; each vector takes SETTLE+1 cycles. done is high at cycle 1 + V*(SETTLE+1), where V = 64 (mode 0) or 1 (mode 1).
- cut_x never changes during a vector's SETTLE/CAPTURE window, so the CUT sees stable inputs for SETTLE+1 cycles before sampling.
- start while busy or in DONE: ignored, no effect on the current run.
- abort in SETTLE or CAPTURE:
  - next state IDLE, busy=0, no done pulse;
  - signature holds its partial value; cut_x returns to 0;
  - entries already captured keep their values.
- abort in IDLE takes priority over a simultaneous start (stays IDLE). abort in DONE is ignored; done still pulses.
- Read port: synchronous and usable in any state. A read and a capture to the same address in the same cycle returns the old data.
- Reset asserted mid-run: immediately returns to the reset values above; a new start is needed.
- Counter is 8 bits; vector increment never wraps because the run ends at the terminal vector.

Test Plan:
- Reset, then mode=1, vec_in=6'h15, stub CUT f=x[3:0], SETTLE=2 → cut_x=6'h15 at cycle 1; done pulses at cycle 4; signature=16'h0005; read addr 6'h15 → rd_data=4'h5.
- mode=0, same stub, SETTLE=2 → busy high for cycles 1..192; done at cycle 193; cut_x=6'h3F at done. Read back all 64 addresses → rd_data=addr[3:0] for every entry; signature matches the bench MISR model.
- mode=0 with start re-pulsed at cycles 10 and 100 → ignored; single done at cycle 193; results identical to the previous run.
- abort at cycle 50 of an exhaustive run → busy=0 at cycle 51, no done; cut_x=0; entries 0..15 hold valid data.
- start and abort together in IDLE → stays IDLE, busy remains 0. Then rst pulsed at cycle 20 of a run → outputs return to reset values asynchronously; the next start completes normally.
- SETTLE=1 versus SETTLE=5 with a CUT model that delays outputs by SETTLE-1 cycles → captured table correct in both cases; done at cycles 129 and 385 respectively.
